// File: rtl/l2_tlb_refill_pkg.sv
// l2_tlb_refill_pkg: shared TLB geometry, entry field offsets, FSM/side enums and page-mask expansion.
package l2_tlb_refill_pkg;
  localparam int ENTRIES = 64;
  localparam int SEARCH_WAYS = 8;
  localparam int IDX_W = 6;
  localparam int GRPS = ENTRIES / SEARCH_WAYS;
  localparam int GRP_W = $clog2(GRPS);
  localparam int WAY_W = $clog2(SEARCH_WAYS);
  localparam int ENTRY_W = 79;
  localparam int G0_BIT = 0;
  localparam int G1_BIT = 26;
  typedef logic [ENTRY_W-1:0] entry_t;
  typedef enum logic [1:0] {IDLE, SEARCH, RESP} state_t;
  typedef enum logic [1:0] {SIDE_I, SIDE_D, SIDE_P} side_t;
  function automatic logic [18:0] vpn_mask(input logic [14:0] pm);
    return {4'hf, ~pm};
  endfunction
endpackage

// File: rtl/l2_tlb_refill_group_match.sv
// l2_tlb_refill_group_match: combinational hit vector for one group of SEARCH_WAYS entries.
module l2_tlb_refill_group_match
  import l2_tlb_refill_pkg::*;
(
  input  logic [18:0]            vpn2 [SEARCH_WAYS],
  input  logic [7:0]             asid [SEARCH_WAYS],
  input  logic [SEARCH_WAYS-1:0] glob,
  input  logic [18:0]            vpn,
  input  logic [7:0]             cur_asid,
  input  logic [18:0]            mask,
  output logic [SEARCH_WAYS-1:0] hit
);
  for (genvar k = 0; k < SEARCH_WAYS; k++) begin : g_way
    assign hit[k] = ((vpn & mask) == (vpn2[k] & mask)) && (glob[k] || asid[k] == cur_asid);
  end
endmodule

// File: rtl/l2_tlb_refill.sv
// l2_tlb_refill: 64-entry L2 TLB with grouped refill search for I/D L1 TLBs.
// Optional TLBP search port enabled by defining L2_TLB_PROBE_EN.
module l2_tlb_refill
  import l2_tlb_refill_pkg::*;
(
  input  logic               clk,
  input  logic               resetn,
  input  logic               i_req,
  input  logic [31:0]        i_vaddr,
  output logic               i_ld_en,
  output logic               i_miss,
  input  logic               d_req,
  input  logic [31:0]        d_vaddr,
  output logic               d_ld_en,
  output logic               d_miss,
  output logic [ENTRY_W-1:0] ld_tlb,
  output logic [IDX_W-1:0]   ld_index,
  input  logic [31:0]        cp0_entryhi,
  input  logic [31:0]        cp0_entrylo0,
  input  logic [31:0]        cp0_entrylo1,
  input  logic [IDX_W-1:0]   cp0_index,
  input  logic [IDX_W-1:0]   cp0_random,
  input  logic [15:0]        cp0_pagemask,
  input  logic               tlbwi_en,
  input  logic               tlbwr_en,
  input  logic               tlbr_en,
  output logic [ENTRY_W-1:0] tlbr_data,
`ifdef L2_TLB_PROBE_EN
  input  logic               tlbp_en,
  output logic               tlbp_done,
  output logic               tlbp_hit,
  output logic [IDX_W-1:0]   tlbp_index,
`endif
  output logic               busy
);
  entry_t tlb [ENTRIES];
  state_t state, state_nx;
  side_t side, side_nx;
  logic [GRP_W-1:0] grp, grp_nx;
  logic [18:0] vpn, vpn_nx;
  logic [7:0] asid, asid_nx;
  logic hit_r, hit_nx;
  entry_t ld_tlb_nx;
  logic [IDX_W-1:0] ld_index_nx;
  logic pe, wr, resp, hit_any;
  logic [IDX_W-1:0] widx, hit_idx;
  logic [WAY_W-1:0] hit_way;
  logic [18:0] w_vpn2 [SEARCH_WAYS];
  logic [7:0] w_asid [SEARCH_WAYS];
  logic [SEARCH_WAYS-1:0] w_glob, hit;
  logic unused_bits;
  assign unused_bits = ^{i_vaddr[12:0], d_vaddr[12:0], cp0_entryhi[12:8], cp0_entrylo0[31:26],
                         cp0_entrylo1[31:26], cp0_pagemask[0]};
`ifdef L2_TLB_PROBE_EN
  assign pe = tlbp_en;
  assign tlbp_done = resp && side == SIDE_P;
  assign tlbp_hit = tlbp_done && hit_r;
  assign tlbp_index = tlbp_hit ? ld_index : '0;
`else
  assign pe = 1'b0;
`endif
  assign wr = tlbwi_en | tlbwr_en;
  assign widx = tlbwi_en ? cp0_index : cp0_random;
  assign busy = state != IDLE;
  // Strobes are gated by resetn so a reset landing on RESP never leaks a response.
  assign resp = state == RESP && resetn;
  assign i_ld_en = resp && side == SIDE_I && hit_r;
  assign i_miss = resp && side == SIDE_I && !hit_r;
  assign d_ld_en = resp && side == SIDE_D && hit_r;
  assign d_miss = resp && side == SIDE_D && !hit_r;
  for (genvar k = 0; k < SEARCH_WAYS; k++) begin : g_sel
    logic [IDX_W-1:0] ix;
    assign ix = {grp, WAY_W'(k)};
    assign w_vpn2[k] = tlb[ix][78:60];
    assign w_asid[k] = tlb[ix][59:52];
    assign w_glob[k] = tlb[ix][G0_BIT] & tlb[ix][G1_BIT];
  end
  l2_tlb_refill_group_match u_match (
    .vpn2     (w_vpn2),
    .asid     (w_asid),
    .glob     (w_glob),
    .vpn      (vpn),
    .cur_asid (asid),
    .mask     (vpn_mask(cp0_pagemask[15:1])),
    .hit      (hit)
  );
  always_comb begin
    hit_way = '0;
    for (int k = SEARCH_WAYS - 1; k >= 0; k--)
      if (hit[k]) hit_way = WAY_W'(k);
  end
  assign hit_any = |hit;
  assign hit_idx = {grp, hit_way};
  always_comb begin
    state_nx = state;
    side_nx = side;
    grp_nx = grp;
    vpn_nx = vpn;
    asid_nx = asid;
    hit_nx = hit_r;
    ld_tlb_nx = ld_tlb;
    ld_index_nx = ld_index;
    unique case (state)
      IDLE: if (!wr && (pe || d_req || i_req)) begin
        state_nx = SEARCH;
        grp_nx = '0;
        asid_nx = cp0_entryhi[7:0];
        side_nx = pe ? SIDE_P : d_req ? SIDE_D : SIDE_I;
        vpn_nx = pe ? cp0_entryhi[31:13] : d_req ? d_vaddr[31:13] : i_vaddr[31:13];
      end
      // An array write aborts the current group so no stale match is returned.
      SEARCH: if (wr) grp_nx = '0;
      else if (hit_any) begin
        state_nx = RESP;
        hit_nx = 1'b1;
        ld_tlb_nx = tlb[hit_idx];
        ld_index_nx = hit_idx;
      end else if (grp == GRP_W'(GRPS - 1)) begin
        state_nx = RESP;
        hit_nx = 1'b0;
      end else grp_nx = grp + 1'b1;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      side <= SIDE_I;
      grp <= '0;
      vpn <= '0;
      asid <= '0;
      hit_r <= 1'b0;
      ld_tlb <= '0;
      ld_index <= '0;
    end else begin
      state <= state_nx;
      side <= side_nx;
      grp <= grp_nx;
      vpn <= vpn_nx;
      asid <= asid_nx;
      hit_r <= hit_nx;
      ld_tlb <= ld_tlb_nx;
      ld_index <= ld_index_nx;
    end
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < ENTRIES; i++) tlb[i] <= '0;
      tlbr_data <= '0;
    end else begin
      if (wr) tlb[widx] <= {cp0_entryhi[31:13], cp0_entryhi[7:0], cp0_entrylo1[25:0], cp0_entrylo0[25:0]};
      if (tlbr_en) tlbr_data <= tlb[cp0_index];
    end
  end
endmodule

// File: tb/tb_l2_tlb_refill.sv
// tb_l2_tlb_refill: directed scoreboard bench; stimulus queues expected strobes, a monitor checks them.
module tb_l2_tlb_refill;
  logic clk = 0, resetn;
  logic i_req, d_req, i_ld_en, i_miss, d_ld_en, d_miss, busy;
  logic [31:0] i_vaddr, d_vaddr, cp0_entryhi, cp0_entrylo0, cp0_entrylo1;
  logic [78:0] ld_tlb, tlbr_data;
  logic [5:0] ld_index, cp0_index, cp0_random;
  logic [15:0] cp0_pagemask;
  logic tlbwi_en, tlbwr_en, tlbr_en;
  localparam logic [3:0] K_ILD = 4'b1000, K_IMISS = 4'b0100, K_DLD = 4'b0010, K_DMISS = 4'b0001;
  typedef struct {logic [3:0] kind; int cyc; logic [5:0] idx; logic [78:0] ent;} exp_t;
  exp_t q[$];
  logic [78:0] mdl [64];
  int n_cmp = 0, n_bad = 0, n_seen = 0, cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  l2_tlb_refill dut (
    .clk(clk), .resetn(resetn), .i_req(i_req), .i_vaddr(i_vaddr), .i_ld_en(i_ld_en), .i_miss(i_miss),
    .d_req(d_req), .d_vaddr(d_vaddr), .d_ld_en(d_ld_en), .d_miss(d_miss), .ld_tlb(ld_tlb),
    .ld_index(ld_index), .cp0_entryhi(cp0_entryhi), .cp0_entrylo0(cp0_entrylo0),
    .cp0_entrylo1(cp0_entrylo1), .cp0_index(cp0_index), .cp0_random(cp0_random),
    .cp0_pagemask(cp0_pagemask), .tlbwi_en(tlbwi_en), .tlbwr_en(tlbwr_en), .tlbr_en(tlbr_en),
    .tlbr_data(tlbr_data), .busy(busy)
  );
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask
  always @(negedge clk) begin
    logic [3:0] k;
    exp_t e;
    k = {i_ld_en, i_miss, d_ld_en, d_miss};
    if (k != 4'b0) begin
      n_seen++;
      if (q.size() == 0) chk("unexpected_strobe", 128'(k), 128'(0));
      else begin
        e = q.pop_front();
        chk("strobe_kind", 128'(k), 128'(e.kind));
        chk("strobe_cycle", 128'(cyc), 128'(e.cyc));
        if (e.kind[3] | e.kind[1]) begin
          chk("ld_index", 128'(ld_index), 128'(e.idx));
          chk("ld_tlb", 128'(ld_tlb), 128'(e.ent));
        end
      end
    end
  end
  task automatic wr_entry(input logic [5:0] ix, input logic [18:0] vpn2, input logic [7:0] as, input logic g);
    logic [25:0] lo0, lo1;
    lo0 = {18'h0, 1'b1, ix, g};
    lo1 = {12'habc, 6'h0, ix, 1'b0, g};
    mdl[ix] = {vpn2, as, lo1, lo0};
    cp0_entryhi = {vpn2, 5'h1f, as};
    cp0_entrylo0 = {6'h3f, lo0};
    cp0_entrylo1 = {6'h3f, lo1};
    cp0_index = ix;
    tlbwi_en = 1;
    @(posedge clk); #1;
    tlbwi_en = 0;
  endtask
  task automatic expect_ev(input logic [3:0] kd, input int c, input logic [5:0] ix);
    exp_t e;
    e.kind = kd; e.cyc = c; e.idx = ix; e.ent = mdl[ix];
    q.push_back(e);
  endtask
  task automatic wait_seen(input int tgt);
    for (int i = 0; i < 40 && n_seen < tgt; i++) @(posedge clk);
    if (n_seen < tgt) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_timeout: seen %0d strobes, expected %0d", n_seen, tgt);
    end
    #1;
  endtask
  task automatic rd_chk(input logic [5:0] ix, input logic [78:0] req, input string nm);
    cp0_index = ix;
    tlbr_en = 1;
    @(posedge clk); #1;
    tlbr_en = 0;
    chk(nm, 128'(tlbr_data), 128'(req));
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int c;
    resetn = 0; i_req = 0; d_req = 0; i_vaddr = 0; d_vaddr = 0;
    cp0_entryhi = 0; cp0_entrylo0 = 0; cp0_entrylo1 = 0; cp0_index = 0; cp0_random = 0;
    cp0_pagemask = 0; tlbwi_en = 0; tlbwr_en = 0; tlbr_en = 0;
    for (int i = 0; i < 64; i++) mdl[i] = '0;
    repeat (3) @(posedge clk); #1;
    chk("rst_busy", 128'(busy), 0);
    chk("rst_strobes", 128'({i_ld_en, i_miss, d_ld_en, d_miss}), 0);
    chk("rst_ld_tlb", 128'(ld_tlb), 0);
    chk("rst_ld_index", 128'(ld_index), 0);
    chk("rst_tlbr_data", 128'(tlbr_data), 0);
    resetn = 1;
    rd_chk(6'd5, '0, "tlbr_after_reset");
    // 1: single hit in group 0
    wr_entry(6'd5, 19'h200, 8'h03, 1'b0);
    rd_chk(6'd5, mdl[5], "tlbr_idx5");
    cp0_index = 6'd6;
    @(posedge clk); #1;
    chk("tlbr_hold", 128'(tlbr_data), 128'(mdl[5]));
    cp0_entryhi = 32'h3; d_vaddr = 32'h0040_0000; d_req = 1;
    expect_ev(K_DLD, cyc + 2, 6'd5);
    wait_seen(n_seen + 1);
    d_req = 0;
    // 2: asid mismatch forces full scan to miss
    cp0_entryhi = 32'h4; i_vaddr = 32'h0040_0000; i_req = 1;
    expect_ev(K_IMISS, cyc + 9, 6'd0);
    @(posedge clk); #1;
    chk("busy_search", 128'(busy), 1);
    wait_seen(n_seen + 1);
    i_req = 0;
    // 3: simultaneous requests, D first
    wr_entry(6'd20, 19'h300, 8'h03, 1'b0);
    cp0_entryhi = 32'h3; d_vaddr = 32'h0040_0000; i_vaddr = {19'h300, 13'h0};
    d_req = 1; i_req = 1; c = cyc;
    expect_ev(K_DLD, c + 2, 6'd5);
    expect_ev(K_ILD, c + 7, 6'd20);
    wait_seen(n_seen + 1);
    d_req = 0;
    wait_seen(n_seen + 1);
    i_req = 0;
    // 4: two matches, lowest index wins
    wr_entry(6'd13, 19'h123, 8'h03, 1'b0);
    wr_entry(6'd9, 19'h123, 8'h03, 1'b0);
    cp0_entryhi = 32'h3; d_vaddr = {19'h123, 13'h1abc}; d_req = 1;
    expect_ev(K_DLD, cyc + 3, 6'd9);
    wait_seen(n_seen + 1);
    d_req = 0;
    // 5: write while scanning group 3 restarts the scan
    cp0_entryhi = 32'h3; d_vaddr = {19'h7777, 13'h0}; d_req = 1; c = cyc;
    expect_ev(K_DMISS, c + 13, 6'd0);
    repeat (4) @(posedge clk); #1;
    wr_entry(6'd40, 19'h1111, 8'h03, 1'b0);
    wait_seen(n_seen + 1);
    d_req = 0;
    // 6: global entry at index 63, any asid
    wr_entry(6'd63, 19'h4abc, 8'h55, 1'b1);
    cp0_entryhi = 32'h99; i_vaddr = {19'h4abc, 13'h0}; i_req = 1;
    expect_ev(K_ILD, cyc + 9, 6'd63);
    wait_seen(n_seen + 1);
    i_req = 0;
    // reset mid-scan: no strobe, array cleared
    cp0_entryhi = 32'h99; d_vaddr = {19'h4abc, 13'h0}; d_req = 1;
    repeat (4) @(posedge clk); #1;
    d_req = 0; resetn = 0;
    @(posedge clk); #1;
    resetn = 1;
    chk("busy_after_reset", 128'(busy), 0);
    for (int i = 0; i < 64; i++) mdl[i] = '0;
    repeat (12) @(posedge clk); #1;
    rd_chk(6'd63, '0, "tlbr_cleared");
    // page mask ignores the low vpn2 bits
    wr_entry(6'd2, 19'h200, 8'h03, 1'b0);
    cp0_pagemask = 16'h0006; cp0_entryhi = 32'h3; d_vaddr = {19'h203, 13'h0}; d_req = 1;
    expect_ev(K_DLD, cyc + 2, 6'd2);
    wait_seen(n_seen + 1);
    d_req = 0;
    cp0_pagemask = 16'h0000; cp0_entryhi = 32'h3; d_req = 1;
    expect_ev(K_DMISS, cyc + 9, 6'd0);
    wait_seen(n_seen + 1);
    d_req = 0;
    repeat (3) @(posedge clk); #1;
    chk("queue_empty", 128'(q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
